// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared constants and helpers for the MIPS inter-stage pipeline registers
package pipe_stage_reg_pkg;

    // Default PC values after reset and on interrupt flush.
    localparam logic [31:0] DEF_INIT_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_TRAP_PC = 32'h0000_4180;

    // Default sideband widths.
    localparam int unsigned PIPE_EXC_W  = 5;
    localparam int unsigned PIPE_TNEW_W = 2;

    // Cause.ExcCode values carried in the exception sideband.
    localparam logic [PIPE_EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [PIPE_EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [PIPE_EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [PIPE_EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [PIPE_EXC_W-1:0] EXC_OV   = 5'd12;

    // What the register does on the next edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_TRAP   = 2'd3
    } stage_act_e;

    // Priority resolution: interrupt beats flush, flush beats stall.
    function automatic stage_act_e select_act(
        input logic int_req,
        input logic flush,
        input logic stall
    );
        stage_act_e act;
        act = ACT_LOAD;
        if (int_req) begin
            act = ACT_TRAP;
        end else if (flush) begin
            act = ACT_BUBBLE;
        end else if (stall) begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_tnew_ctr.sv
// rtl/pipe_stage_reg_tnew_ctr.sv - Tnew register with load, saturating decrement and clear
module pipe_tnew_ctr #(
    parameter int unsigned TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [TNEW_W-1:0] load_val,
    input  logic              dec,
    output logic [TNEW_W-1:0] tnew
);

    // Clear wins over load, load over decrement; decrement stops at zero so Tnew never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tnew <= '0;
        end else if (clr) begin
            tnew <= '0;
        end else if (load) begin
            tnew <= load_val;
        end else if (dec && (tnew != '0)) begin
            tnew <= tnew - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with hold, bubble and trap flush
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned     DATA_W      = 128,
    parameter int unsigned     PC_W        = 32,
    parameter logic [PC_W-1:0] INIT_PC     = PC_W'(DEF_INIT_PC),
    parameter logic [PC_W-1:0] TRAP_PC     = PC_W'(DEF_TRAP_PC),
    parameter int unsigned     TNEW_W      = PIPE_TNEW_W,
    parameter int unsigned     EXC_W       = PIPE_EXC_W,
    parameter bit              DEC_ON_HOLD = 1'b1,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              int_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic [4:0]        in_a3,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic [4:0]        out_a3,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [CNT_W-1:0]  bubble_cnt
);

    stage_act_e        act;
    logic              tnew_clr;
    logic              tnew_load;
    logic              tnew_dec;
    logic [TNEW_W-1:0] tnew_load_val;

    assign act = select_act(int_req, flush, stall);

    // A non-valid slot must never advertise a pending result.
    assign tnew_clr      = (act == ACT_TRAP) || (act == ACT_BUBBLE);
    assign tnew_load     = (act == ACT_LOAD);
    assign tnew_load_val = in_valid ? in_tnew : '0;
    assign tnew_dec      = (act == ACT_HOLD) && DEC_ON_HOLD;

    pipe_tnew_ctr #(
        .TNEW_W (TNEW_W)
    ) u_tnew_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (tnew_clr),
        .load     (tnew_load),
        .load_val (tnew_load_val),
        .dec      (tnew_dec),
        .tnew     (out_tnew)
    );

    // Payload and sideband: a bubble keeps PC/BD so EPC is right for the flushed slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pc    <= INIT_PC;
            out_bd    <= 1'b0;
            out_exc   <= '0;
            out_a3    <= '0;
        end else begin
            case (act)
                ACT_TRAP: begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_pc    <= TRAP_PC;
                    out_bd    <= 1'b0;
                    out_exc   <= '0;
                    out_a3    <= '0;
                end
                ACT_BUBBLE: begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_pc    <= in_pc;
                    out_bd    <= in_bd;
                    out_exc   <= '0;
                    out_a3    <= '0;
                end
                ACT_HOLD: begin
                    out_valid <= out_valid;
                end
                default: begin
                    out_valid <= in_valid;
                    out_data  <= in_data;
                    out_pc    <= in_pc;
                    out_bd    <= in_bd;
                    out_exc   <= in_exc;
                    out_a3    <= in_valid ? in_a3 : 5'd0;
                end
            endcase
        end
    end

    // Count flush-inserted bubbles, sticking at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if ((act == ACT_BUBBLE) && !(&bubble_cnt)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int DATA_W = 128;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              int_req;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_pc;
    logic              in_bd;
    logic [4:0]        in_exc;
    logic [4:0]        in_a3;
    logic [1:0]        in_tnew;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_pc;
    logic              out_bd;
    logic [4:0]        out_exc;
    logic [4:0]        out_a3;
    logic [1:0]        out_tnew;
    logic [15:0]       bubble_cnt;

    logic              d2_valid;
    logic [7:0]        d2_data;
    logic [31:0]       d2_pc;
    logic              d2_bd;
    logic [4:0]        d2_exc;
    logic [4:0]        d2_a3;
    logic [1:0]        d2_tnew;
    logic [1:0]        d2_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [DATA_W-1:0] PAT_A5 = {4{32'hA5A5_A5A5}};
    localparam logic [DATA_W-1:0] PAT_5A = {4{32'h5A5A_5A5A}};
    localparam logic [DATA_W-1:0] PAT_C3 = {4{32'hC3C3_3C3C}};

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_req(int_req),
        .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc), .in_bd(in_bd),
        .in_exc(in_exc), .in_a3(in_a3), .in_tnew(in_tnew),
        .out_valid(out_valid), .out_data(out_data), .out_pc(out_pc), .out_bd(out_bd),
        .out_exc(out_exc), .out_a3(out_a3), .out_tnew(out_tnew), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_req(int_req),
        .in_valid(in_valid), .in_data(in_data[7:0]), .in_pc(in_pc), .in_bd(in_bd),
        .in_exc(in_exc), .in_a3(in_a3), .in_tnew(in_tnew),
        .out_valid(d2_valid), .out_data(d2_data), .out_pc(d2_pc), .out_bd(d2_bd),
        .out_exc(d2_exc), .out_a3(d2_a3), .out_tnew(d2_tnew), .bubble_cnt(d2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 0; flush = 0; int_req = 0;
        in_valid = 0; in_data = '0; in_pc = '0; in_bd = 0; in_exc = '0; in_a3 = '0; in_tnew = '0;
        tick(); tick();
        n_checks++; if (out_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", out_pc, 32'h0000_3000); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_a3 !== 5'd0) begin n_fail++; $display("FAIL reset_a3: got %0d expected 0", out_a3); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_checks++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bubble_cnt); end
        reset = 1'b1;
    endtask

    task automatic test_load();
        in_valid = 1; in_pc = 32'h0000_3004; in_a3 = 5'd8; in_tnew = 2'd2; in_data = PAT_A5;
        in_bd = 0; in_exc = EXC_RI;
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_pc !== 32'h0000_3004) begin n_fail++; $display("FAIL load_pc: got %h expected %h", out_pc, 32'h0000_3004); end
        n_checks++; if (out_a3 !== 5'd8) begin n_fail++; $display("FAIL load_a3: got %0d expected 8", out_a3); end
        n_checks++; if (out_tnew !== 2'd2) begin n_fail++; $display("FAIL load_tnew: got %0d expected 2", out_tnew); end
        n_checks++; if (out_data !== PAT_A5) begin n_fail++; $display("FAIL load_data: got %h expected %h", out_data, PAT_A5); end
        n_checks++; if (out_exc !== 5'd10) begin n_fail++; $display("FAIL load_exc: got %0d expected 10", out_exc); end
    endtask

    task automatic test_stall();
        logic [1:0] exp_tnew [3];
        exp_tnew[0] = 2'd1; exp_tnew[1] = 2'd0; exp_tnew[2] = 2'd0;
        stall = 1;
        in_pc = 32'hDEAD_BEEC; in_a3 = 5'd17; in_tnew = 2'd3; in_data = PAT_5A; in_exc = EXC_OV; in_bd = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_tnew !== exp_tnew[i]) begin n_fail++; $display("FAIL stall_tnew[%0d]: got %0d expected %0d", i, out_tnew, exp_tnew[i]); end
            n_checks++; if (out_pc !== 32'h0000_3004) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, out_pc, 32'h0000_3004); end
            n_checks++; if (out_a3 !== 5'd8) begin n_fail++; $display("FAIL stall_a3[%0d]: got %0d expected 8", i, out_a3); end
            n_checks++; if (out_data !== PAT_A5) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", i, out_data, PAT_A5); end
            n_checks++; if ({out_valid, out_bd, out_exc} !== {1'b1, 1'b0, 5'd10}) begin n_fail++; $display("FAIL stall_side[%0d]: got %b expected %b", i, {out_valid, out_bd, out_exc}, {1'b1, 1'b0, 5'd10}); end
        end
    endtask

    task automatic test_flush_stall();
        stall = 1; flush = 1; in_pc = 32'h0000_3010; in_bd = 1; in_valid = 1; in_a3 = 5'd9; in_tnew = 2'd2;
        tick();
        n_checks++; if (out_pc !== 32'h0000_3010) begin n_fail++; $display("FAIL flush_pc: got %h expected %h", out_pc, 32'h0000_3010); end
        n_checks++; if (out_bd !== 1'b1) begin n_fail++; $display("FAIL flush_bd: got %b expected 1", out_bd); end
        n_checks++; if (out_a3 !== 5'd0) begin n_fail++; $display("FAIL flush_a3: got %0d expected 0", out_a3); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        n_checks++; if ({out_tnew, out_exc} !== 7'd0) begin n_fail++; $display("FAIL flush_tnew_exc: got %b expected 0", {out_tnew, out_exc}); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL flush_data: got %h expected 0", out_data); end
        n_checks++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 1", bubble_cnt); end
    endtask

    task automatic test_int_flush();
        int_req = 1; flush = 1; stall = 0; in_pc = 32'h0000_3014; in_bd = 1;
        tick();
        n_checks++; if (out_pc !== 32'h0000_4180) begin n_fail++; $display("FAIL int_pc: got %h expected %h", out_pc, 32'h0000_4180); end
        n_checks++; if (out_bd !== 1'b0) begin n_fail++; $display("FAIL int_bd: got %b expected 0", out_bd); end
        n_checks++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL int_cnt: got %0d expected 1", bubble_cnt); end
        n_checks++; if ({out_valid, out_a3, out_tnew} !== 8'd0) begin n_fail++; $display("FAIL int_side: got %b expected 0", {out_valid, out_a3, out_tnew}); end
        int_req = 0; flush = 0;
    endtask

    task automatic test_invalid_load();
        stall = 0; flush = 0; int_req = 0;
        in_valid = 0; in_a3 = 5'd31; in_tnew = 2'd2; in_pc = 32'h0000_3020; in_data = PAT_C3; in_exc = EXC_OV; in_bd = 1;
        tick();
        n_checks++; if (out_a3 !== 5'd0) begin n_fail++; $display("FAIL inval_a3: got %0d expected 0", out_a3); end
        n_checks++; if (out_tnew !== 2'd0) begin n_fail++; $display("FAIL inval_tnew: got %0d expected 0", out_tnew); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inval_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_pc !== 32'h0000_3020) begin n_fail++; $display("FAIL inval_pc: got %h expected %h", out_pc, 32'h0000_3020); end
        n_checks++; if (out_data !== PAT_C3) begin n_fail++; $display("FAIL inval_data: got %h expected %h", out_data, PAT_C3); end
        n_checks++; if ({out_bd, out_exc} !== {1'b1, 5'd12}) begin n_fail++; $display("FAIL inval_bd_exc: got %b expected %b", {out_bd, out_exc}, {1'b1, 5'd12}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        logic [4:0]  a3s [3];
        logic [1:0]  tns [3];
        pcs[0] = 32'h0000_3100; pcs[1] = 32'h0000_3104; pcs[2] = 32'h0000_3108;
        a3s[0] = 5'd1; a3s[1] = 5'd2; a3s[2] = 5'd31;
        tns[0] = 2'd0; tns[1] = 2'd1; tns[2] = 2'd3;
        stall = 0; flush = 0; int_req = 0; in_valid = 1; in_bd = 0; in_exc = EXC_INT;
        for (int i = 0; i < 3; i++) begin
            in_pc = pcs[i]; in_a3 = a3s[i]; in_tnew = tns[i]; in_data = {4{pcs[i]}};
            tick();
            n_checks++; if (out_pc !== pcs[i]) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, out_pc, pcs[i]); end
            n_checks++; if (out_a3 !== a3s[i]) begin n_fail++; $display("FAIL b2b_a3[%0d]: got %0d expected %0d", i, out_a3, a3s[i]); end
            n_checks++; if (out_tnew !== tns[i]) begin n_fail++; $display("FAIL b2b_tnew[%0d]: got %0d expected %0d", i, out_tnew, tns[i]); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
        end
    endtask

    task automatic test_async_reset();
        stall = 1; flush = 1;
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (out_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL areset_pc: got %h expected %h", out_pc, 32'h0000_3000); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_a3 !== 5'd0) begin n_fail++; $display("FAIL areset_a3: got %0d expected 0", out_a3); end
        n_checks++; if (out_tnew !== 2'd0) begin n_fail++; $display("FAIL areset_tnew: got %0d expected 0", out_tnew); end
        n_checks++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL areset_cnt: got %0d expected 0", bubble_cnt); end
        n_checks++; if (d2_cnt !== 2'd0) begin n_fail++; $display("FAIL areset_cnt_small: got %0d expected 0", d2_cnt); end
        stall = 0; flush = 0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_cnt_saturation();
        logic [1:0] exp_small;
        logic [15:0] exp_big;
        stall = 0; int_req = 0; flush = 1; in_pc = 32'h0000_3010; in_bd = 1; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_big   = 16'(i + 1);
            exp_small = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_checks++; if (d2_cnt !== exp_small) begin n_fail++; $display("FAIL sat_cnt_small[%0d]: got %0d expected %0d", i, d2_cnt, exp_small); end
            n_checks++; if (bubble_cnt !== exp_big) begin n_fail++; $display("FAIL sat_cnt_big[%0d]: got %0d expected %0d", i, bubble_cnt, exp_big); end
        end
        n_checks++; if ({d2_pc, d2_bd, d2_a3} !== {32'h0000_3010, 1'b1, 5'd0}) begin n_fail++; $display("FAIL sat_small_side: got %h expected %h", {d2_pc, d2_bd, d2_a3}, {32'h0000_3010, 1'b1, 5'd0}); end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_int_flush();
        test_invalid_load();
        test_back_to_back();
        test_async_reset();
        test_cnt_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS CPU; one instance per boundary (F/D, D/E, E/M, M/W).
- Carries a generic payload plus the control sideband: PC, branch-delay flag, exception code, destination register A3, Tnew and valid.
- Adds behaviour over the fixed per-boundary registers:
  - Hold on stall.
  - A bubble that keeps PC and BD, so EPC stays correct for a flushed slot.
  - Interrupt flush to the trap vector.
  - Tnew countdown while held.
  - A bubble-insertion counter for performance tests.

Parameters:
DATA_W, 128, payload width (e.g. V1, V2, E32, Instr concatenated)
PC_W, 32, PC width
INIT_PC, 32'h0000_3000, PC value after reset
TRAP_PC, 32'h0000_4180, PC value loaded on interrupt flush
TNEW_W, 2, Tnew field width
EXC_W, 5, exception code width
DEC_ON_HOLD, 1, 1 = stored Tnew decrements (saturating) on each stalled cycle
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
stall  in  1  hold current contents
flush  in  1  insert bubble, keep PC/BD from input
int_req  in  1  interrupt/exception flush
in_valid  in  1  upstream slot holds a real instruction
in_data  in  DATA_W  payload
in_pc  in  PC_W  upstream PC
in_bd  in  1  upstream branch-delay flag
in_exc  in  EXC_W  upstream exception code
in_a3  in  5  destination register
in_tnew  in  TNEW_W  Tnew as seen upstream of this register
out_valid  out  1  stage holds a real instruction
out_data  out  DATA_W  registered payload
out_pc  out  PC_W  registered PC
out_bd  out  1  registered BD
out_exc  out  EXC_W  registered exception code
out_a3  out  5  registered destination (0 in a bubble)
out_tnew  out  TNEW_W  cycles until result is available
bubble_cnt  out  CNT_W  count of bubbles inserted by flush

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - out_pc = INIT_PC.
  - All other outputs = 0, including bubble_cnt.
  - Release of reset is synchronous to the next clk edge; there are no initial blocks.
- At each rising edge, the first matching condition wins:
  1. int_req=1 (interrupt flush):
     - out_pc <= TRAP_PC; out_bd <= 0.
     - out_data, out_exc, out_a3, out_tnew, out_valid <= 0.
     - bubble_cnt unchanged.
  2. flush=1 (bubble, takes priority even if stall=1):
     - out_pc <= in_pc; out_bd <= in_bd.
     - out_data, out_exc, out_a3, out_tnew, out_valid <= 0.
     - bubble_cnt <= bubble_cnt+1, saturating at all-ones.
  3. stall=1 (hold):
     - All fields hold.
     - If DEC_ON_HOLD=1 and out_tnew≠0: out_tnew <= out_tnew-1.
  4. Otherwise (load):
     - Every field <= its input.
     - out_valid <= in_valid.
     - out_tnew <= in_tnew.
     - If in_valid=0: out_a3 <= 0 and out_tnew <= 0, so a non-valid slot never claims a register.
- Latency: 1 cycle input to output.
- No combinational path from any input to any output.
- out_a3=0 always means "no write"; the hazard unit relies on this.
- Tnew never underflows: decrement saturates at 0.
- in_tnew is passed through unchanged on load; the consumer stage performs the per-stage decrement.
- Reset asserted mid-stall or mid-flush wins immediately, asynchronously.

Decomposition:
- Shared constants package: INIT_PC and TRAP_PC default values, EXC_W, ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), TNEW_W.
- One natural sub-module: pipe_tnew_ctr.
  - Holds the Tnew register.
  - Handles load, saturating decrement and clear.
  - Reused by the hazard unit's stall model.

Test Plan:
- Reset: hold reset=0 mid-cycle -> immediately out_pc=0x3000, out_valid=0, out_a3=0, bubble_cnt=0, with no clk edge required.
- Load: in_valid=1, in_pc=0x3004, in_a3=8, in_tnew=2, in_data=0xA5A5.. -> after 1 edge the outputs equal the inputs and out_tnew=2.
- Stall with DEC_ON_HOLD=1: hold out_tnew=2 for 3 cycles -> out_tnew = 1, 0, 0. All other fields unchanged.
- Flush with stall both set: in_pc=0x3010, in_bd=1 -> out_pc=0x3010, out_bd=1, out_a3=0, out_valid=0, bubble_cnt increments by 1. At CNT_W=2 from value 3, bubble_cnt stays 3.
- int_req with flush both set: -> out_pc=0x4180, out_bd=0, bubble_cnt unchanged.
- Load of in_valid=0 with in_a3=31, in_tnew=2: -> out_a3=0, out_tnew=0.
